// File: rtl/nios_irq_agg_pkg.sv
// Shared constants for the Nios II interrupt aggregator.
//   ADDR_*           register word addresses on the Avalon-MM slave port
//   ACTIVE_VALID_BIT bit position of the valid flag in the ACTIVE register
//   ACTIVE_IDX_W     width of the source index field in the ACTIVE register
package nios_irq_agg_pkg;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_FORCE   = 3'd4;

  localparam int ACTIVE_VALID_BIT = 15;
  localparam int ACTIVE_IDX_W     = 4;

endpackage

// File: rtl/nios_system_irq_aggregator_if.sv
// Avalon-MM slave bus of the interrupt aggregator.
//   address    register word address
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   readdata   registered read data (valid one cycle after address)
// Modports: master (CPU / bus fabric side), slave (aggregator side).
interface nios_system_irq_aggregator_if #(
  parameter int DATA_W = 16
);
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_irq_prio_enc.sv
// Combinational lowest-index-first priority encoder.
//   req   in   NUM_IRQ       request vector (bit 0 = highest priority)
//   valid out  1             any request set
//   idx   out  ACTIVE_IDX_W  lowest set index; 0 when no request is set
module nios_irq_prio_enc
  import nios_irq_agg_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]      req,
  output logic                    valid,
  output logic [ACTIVE_IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last assignment.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = ACTIVE_IDX_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/nios_system_irq_aggregator.sv
// Avalon-MM interrupt aggregator in front of the Nios II CPU.
// Latches up to NUM_IRQ source lines (bit 0 = system timer) into a pending
// register with per-source mask and edge/level select, reports the
// highest-priority active source and drives one irq to the CPU.
//   clk     in   1        system clock
//   reset   in   1        asynchronous, active-high reset
//   bus     slave         Avalon-MM register port (see interface file)
//   irq_in  in   NUM_IRQ  source interrupt lines
//   irq     out  1        aggregated interrupt, |(pending & mask)
// Register map: 0 PENDING (R/W1C), 1 MASK, 2 EDGE, 3 ACTIVE (R),
//               4 FORCE (W, reads 0), 5-7 reserved.
// Build option: define IRQ_AGG_SYNC_EN to insert a 2-flop synchronizer on
// every irq_in line (adds 2 cycles of input-to-pending latency).
module nios_system_irq_aggregator
  import nios_irq_agg_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int DATA_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  nios_system_irq_aggregator_if.slave bus,
  input  logic [NUM_IRQ-1:0]   irq_in,
  output logic                 irq
);

  logic [NUM_IRQ-1:0]      irq_src;
  logic [NUM_IRQ-1:0]      irq_d;
  logic [NUM_IRQ-1:0]      pending, pending_nxt;
  logic [NUM_IRQ-1:0]      mask;
  logic [NUM_IRQ-1:0]      edge_mode;
  logic [DATA_W-1:0]       readdata_q, read_mux;
  logic                    act_valid;
  logic [ACTIVE_IDX_W-1:0] act_idx;

  // Write strobes
  logic               wr_en;
  logic               wr_pending, wr_mask, wr_edge, wr_force;
  logic [NUM_IRQ-1:0] wdata;
  logic               unused_wdata;

  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign wr_pending = wr_en && (bus.address == ADDR_PENDING);
  assign wr_mask    = wr_en && (bus.address == ADDR_MASK);
  assign wr_edge    = wr_en && (bus.address == ADDR_EDGE);
  assign wr_force   = wr_en && (bus.address == ADDR_FORCE);
  assign wdata      = bus.writedata[NUM_IRQ-1:0];
  // Bits above NUM_IRQ carry no register state.
  assign unused_wdata = ^bus.writedata;

  // Source conditioning
`ifdef IRQ_AGG_SYNC_EN
  logic [NUM_IRQ-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_src = sync_q2;
`else
  assign irq_src = irq_in;
`endif

  // Pending next-state
  // Edge bits: a new edge or FORCE sets, otherwise W1C clears, otherwise
  // hold -- so an edge coinciding with its own W1C is never lost.
  // Level bits simply track the (conditioned) line.
  logic [NUM_IRQ-1:0] set_bits, clr_bits;

  assign set_bits    = (irq_src & ~irq_d) | (wr_force ? wdata : '0);
  assign clr_bits    = wr_pending ? wdata : '0;
  assign pending_nxt = (edge_mode & (set_bits | (pending & ~clr_bits)))
                     | (~edge_mode & irq_src);

  // State registers
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_d      <= '0;
      pending    <= '0;
      mask       <= '0;
      edge_mode  <= '0;
      readdata_q <= '0;
    end else begin
      irq_d      <= irq_src;
      pending    <= pending_nxt;
      if (wr_mask) mask      <= wdata;
      if (wr_edge) edge_mode <= wdata;
      readdata_q <= read_mux;
    end
  end

  // ACTIVE encoder
  nios_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req   (pending & mask),
    .valid (act_valid),
    .idx   (act_idx)
  );

  // Read mux (registered every cycle, independent of chipselect)
  always_comb begin
    read_mux = '0;
    case (bus.address)
      ADDR_PENDING: read_mux = DATA_W'(pending);
      ADDR_MASK:    read_mux = DATA_W'(mask);
      ADDR_EDGE:    read_mux = DATA_W'(edge_mode);
      ADDR_ACTIVE: begin
        read_mux[ACTIVE_VALID_BIT]   = act_valid;
        read_mux[ACTIVE_IDX_W-1:0]   = act_idx;
      end
      default:      read_mux = '0;
    endcase
  end

  assign bus.readdata = readdata_q;

  // Straight from flops, so reset drops irq without waiting for a clock.
  assign irq = |(pending & mask);

endmodule

// File: tb/tb_nios_system_irq_aggregator.sv
module tb_nios_system_irq_aggregator;
  import nios_irq_agg_pkg::*;

  localparam int NUM_IRQ = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq;

  nios_system_irq_aggregator_if #(.DATA_W(16)) bus ();

  nios_system_irq_aggregator #(
    .NUM_IRQ (NUM_IRQ),
    .DATA_W  (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .irq_in (irq_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected read data queued when the read is issued,
  // compared when the registered readdata appears.
  typedef struct {
    string       name;
    logic [15:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t mon_e;
  logic    rd_track = 1'b0;

  always @(posedge clk) rd_track <= bus.chipselect & bus.write_n;

  always @(negedge clk) begin
    if (rd_track && !reset) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: readdata=%h with nothing queued", bus.readdata);
      end else begin
        mon_e = sb.pop_front();
        if (bus.readdata !== mon_e.exp) begin
          errors++;
          $display("FAIL %s: readdata=%h expected=%h", mon_e.name, bus.readdata, mon_e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus primitives (drive only)
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    sb.push_back('{nm, exp});
    @(negedge clk);
    bus.chipselect = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_IRQ-1:0] lines);
    @(negedge clk);
    irq_in = lines;
    @(negedge clk);
    irq_in = '0;
  endtask

  // Scenarios
  task automatic test_reset;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: irq=%b expected=0", irq);
    end
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("reset_read_addr%0d", a));
    wr(3'd5, 16'hFFFF);
    rd(3'd5, 16'h0000, "reserved_addr5_read");
    rd(ADDR_MASK, 16'h0000, "reserved_write_no_mask");
  endtask

  task automatic test_edge;
    wr(ADDR_EDGE, 16'h0001);
    wr(ADDR_MASK, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL edge_irq_idle: irq=%b expected=0", irq);
    end
    pulse(8'h01);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL edge_irq_set: irq=%b expected=1", irq);
    end
    rd(ADDR_PENDING, 16'h0001, "edge_pending");
    rd(ADDR_ACTIVE,  16'h8000, "edge_active");
    wr(ADDR_PENDING, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL edge_w1c_irq: irq=%b expected=0", irq);
    end
  endtask

  task automatic test_level;
    wr(ADDR_EDGE, 16'h0000);
    wr(ADDR_MASK, 16'h0008);
    @(negedge clk); irq_in[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL level_irq_set: irq=%b expected=1", irq);
    end
    rd(ADDR_PENDING, 16'h0008, "level_pending");
    wr(ADDR_PENDING, 16'h0008);
    rd(ADDR_PENDING, 16'h0008, "level_w1c_held");
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL level_w1c_irq: irq=%b expected=1", irq);
    end
    @(negedge clk); irq_in[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL level_drop_irq: irq=%b expected=0", irq);
    end
    rd(ADDR_PENDING, 16'h0000, "level_drop_pending");
    wr(ADDR_FORCE, 16'h0008);
    rd(ADDR_PENDING, 16'h0000, "level_force_no_effect");
  endtask

  task automatic test_priority;
    wr(ADDR_EDGE, 16'h00FF);
    wr(ADDR_MASK, 16'h00FF);
    pulse(8'h24);
    rd(ADDR_ACTIVE,  16'h8002, "prio_active_2");
    rd(ADDR_PENDING, 16'h0024, "prio_pending");
    wr(ADDR_PENDING, 16'h0004);
    rd(ADDR_ACTIVE,  16'h8005, "prio_active_5");
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL prio_irq: irq=%b expected=1", irq);
    end
    wr(ADDR_PENDING, 16'h00FF);
    rd(ADDR_ACTIVE, 16'h0000, "prio_active_none");
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL prio_clear_irq: irq=%b expected=0", irq);
    end
  endtask

  task automatic test_set_wins;
    pulse(8'h01);
    // New rising edge on bit 0 coincides with W1C of bit 0.
    @(negedge clk);
    bus.address = ADDR_PENDING; bus.writedata = 16'h0001;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    irq_in[0] = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    irq_in[0] = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL set_wins_irq: irq=%b expected=1", irq);
    end
    rd(ADDR_PENDING, 16'h0001, "set_wins_pending");
    wr(ADDR_PENDING, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL set_wins_cleanup_irq: irq=%b expected=0", irq);
    end
  endtask

  task automatic test_force_reset;
    wr(ADDR_MASK,  16'h0000);
    wr(ADDR_FORCE, 16'h0010);
    rd(ADDR_PENDING, 16'h0010, "force_pending");
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL force_masked_irq: irq=%b expected=0", irq);
    end
    rd(ADDR_FORCE, 16'h0000, "force_reads_zero");
    wr(ADDR_MASK, 16'h0010);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL force_unmasked_irq: irq=%b expected=1", irq);
    end
    rd(ADDR_ACTIVE, 16'h8004, "force_active");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL async_reset_irq: irq=%b expected=0", irq);
    end
    checks++;
    if (bus.readdata !== 16'h0000) begin
      errors++; $display("FAIL async_reset_readdata: readdata=%h expected=0000", bus.readdata);
    end
    @(negedge clk);
    reset = 1'b0;
    rd(ADDR_PENDING, 16'h0000, "post_reset_pending");
    rd(ADDR_MASK,    16'h0000, "post_reset_mask");
    rd(ADDR_EDGE,    16'h0000, "post_reset_edge");
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL post_reset_irq: irq=%b expected=0", irq);
    end
  endtask

  initial begin
    irq_in         = '0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_edge();
    test_level();
    test_priority();
    test_set_wins();
    test_force_reset();

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: outstanding=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
